lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the EX_MEM register and an external data-memory port with variable latency.
- Takes MR/MW/func3/address/store data from EX_MEM and drives a req/ack memory bus.
- Generates byte enables and lane-aligned write data, and sign- or zero-extends load data for MEM_WB.
- Asserts a pipeline stall while an access is outstanding, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
- ADDR_W, 32: width of the byte address.
- TIMEOUT, 16: maximum number of WAIT cycles without mem_ack before bus_err. A value of 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MR  in  1  load request from EX_MEM.
- MW  in  1  store request from EX_MEM.
- func3  in  3  RV32I width/sign code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data, taken from the low bits.
- rdata  out  32  extended load data to MEM_WB.
- stall_mem  out  1  freezes PC, IF_ID, ID_EX and EX_MEM.
- access_err  out  1  misaligned or illegal access.
- bus_err  out  1  timeout on the memory bus.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  32  read word; valid when mem_ack=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: rdata, stall_mem, access_err, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
  - The timeout counter clears to 0.
  - Reset in the middle of an access drops mem_req immediately; any late mem_ack is ignored.
- Legality rules:
  - Illegal: MR and MW both 1.
  - Illegal load: func3 is 3, 6 or 7.
  - Illegal store: func3 is greater than 2.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- Store encoding:
  - SB: be = 1<<addr[1:0]; wdata[7:0] replicated to all four lanes.
  - SH: be = addr[1] ? 1100 : 0011; wdata[15:0] replicated to both halves.
  - SW: be = 1111; wdata passed through.
  - Loads use the same be pattern, with mem_wdata=0.
- Load extension, applied to the selected lane of mem_rdata:
  - LB sign-extends; LBU zero-extends.
  - LH sign-extends; LHU zero-extends.
  - LW passes the word through.
- FSM state IDLE:
  - Legal access:
    - stall_mem=1 combinationally in the same cycle.
    - Latch mem_addr={addr[ADDR_W-1:2],2'b00}, mem_be, mem_wdata, mem_we=MW and func3/lane.
    - Set mem_req=1 and go to WAIT. Counter←0.
  - Illegal or misaligned access:
    - No bus request and stall_mem=0.
    - On the next edge register access_err=1 for one cycle, and set rdata←0 if MR.
    - Stay in IDLE.
  - No access: stall_mem=0, hold.
- FSM state WAIT:
  - stall_mem=1 and mem_req=1 held steady; address and data are stable.
  - mem_ack=1:
    - For a load, rdata←extended value.
    - mem_req←0, mem_be←0, mem_we←0.
    - Go to DONE.
  - Otherwise the counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack:
    - mem_req←0, bus_err←1, rdata←0 (for a load).
    - Go to DONE.
  - If ack and timeout coincide, ack wins and bus_err stays 0.
- FSM state DONE:
  - stall_mem=0 and rdata is valid; the pipeline advances at this edge.
  - bus_err is high only during DONE, and only after a timeout.
  - Unconditional transition to IDLE, so the same access cannot re-trigger.
- Latency:
  - Minimum 3 cycles (IDLE, WAIT with ack, DONE), giving 2 stall cycles.
  - General case: 2 + N stall cycles, where N is the number of WAIT cycles before ack.
- rdata holds its value between loads; stores never modify it.
- A mem_ack arriving while in IDLE or DONE is ignored.
- The inputs MR/MW/func3/addr/wdata are sampled only in IDLE; later changes do not affect a latched access.

Test Plan:
- SW: addr=0x104, wdata=0xDEADBEEF, ack on the first WAIT cycle → mem_addr=0x104, be=1111, mem_we=1, mem_wdata=0xDEADBEEF; stall_mem high exactly 2 cycles; no error.
- SB: addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5. Then LB at 0x103 with mem_rdata=0xA5000000 → rdata=0xFFFFFFA5. LBU at the same address → rdata=0x000000A5.
- LH: addr=0x102, mem_rdata=0x8001_1234, ack after 3 WAIT cycles → rdata=0xFFFF8001; stall_mem high 5 cycles. LHU at 0x100 → rdata=0x00001234.
- LW at addr=0x102 → no mem_req, stall_mem=0, access_err pulses for 1 cycle, rdata=0. Same result for MR=MW=1, and for a store with func3=4.
- TIMEOUT=4, load with mem_ack held at 0 → mem_req drops after 4 WAIT cycles, bus_err=1 in DONE, rdata=0, returns to IDLE. A late mem_ack afterwards → no effect.
- Drop rst to 0 during WAIT → mem_req and stall_mem go to 0 immediately. Release rst, then issue a new SW → normal 2-cycle stall.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit bridging EX_MEM to a variable-latency req/ack data-memory port
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MR,
    input  logic              MW,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall_mem,
    output logic              access_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [2:0]       f3_q;
    logic             ld_q;
    logic             access, bad_op, misalign, legal, illegal, timed_out;
    logic [3:0]       be_n;
    logic [31:0]      wd_n, ext;
    logic [7:0]       sel_b;
    logic [15:0]      sel_h;
    assign access    = MR | MW;
    assign bad_op    = (MR & MW) | (MR & (func3 == 3'd3 || func3[2:1] == 2'b11)) | (MW & (func3 > 3'd2));
    assign misalign  = (func3[1:0] == 2'b01 && addr[0]) || (func3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign legal     = access & ~bad_op & ~misalign;
    assign illegal   = access & ~legal;
    assign be_n      = func3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                       func3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_n      = func3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                       func3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    assign sel_b     = 8'(mem_rdata >> {lane_q, 3'b000});
    assign sel_h     = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext       = f3_q[1:0] == 2'b00 ? {{24{sel_b[7] & ~f3_q[2]}}, sel_b} :
                       f3_q[1:0] == 2'b01 ? {{16{sel_h[15] & ~f3_q[2]}}, sel_h} : mem_rdata;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    // stall is raised combinationally on a legal issue so the pipeline freezes in the same cycle; reset forces it low
    assign stall_mem = rst & ((state == IDLE & legal) | (state == WAIT));
    // access FSM: latch the request in IDLE, wait for ack or timeout, present the result for one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            ld_q       <= 1'b0;
            rdata      <= '0;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MW;
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= MW ? wd_n : '0;
                        lane_q    <= addr[1:0];
                        f3_q      <= func3;
                        ld_q      <= MR;
                    end else if (illegal) begin
                        access_err <= 1'b1;
                        if (MR)
                            rdata <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (ld_q)
                            rdata <= ext;
                        mem_req <= 1'b0;
                        mem_be  <= '0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end else if (timed_out) begin
                        if (ld_q)
                            rdata <= '0;
                        mem_req <= 1'b0;
                        mem_be  <= '0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
